dag_addr_gen: RTL and testbench

Data address generator (DAG) sitting directly downstream of the program sequencer. It holds eight index (I), modify (M), length (L) and base (B) registers. On each sequencer-issued memory access it computes a 16-bit effective address, driving the data memory and returning it to the sequencer for indirect jumps and calls. It also serves the sequencer's universal-register reads and writes of its own register file.

---
 rtl/dag_addr_gen.sv | 149 ++++++++++++++
 tb/tb_dag_addr_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dag_addr_gen.sv
// Data address generator: eight I/M/L/B register sets, pre/post-modify addressing and a
// universal-register read/write port. Circular buffering (L/B) is built only with DAG_CIRC_BUF_EN.
module dag_addr_gen #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ps_dg_en,
    input  logic          ps_dg_dgsclt,
    input  logic          ps_dg_mdfy,
    input  logic [2:0]    ps_dg_iadd,
    input  logic [2:0]    ps_dg_madd,
    input  logic [AW-1:0] ps_dg_immdt,
    input  logic          ps_dg_wrt_en,
    input  logic [4:0]    ps_dg_wrt_add,
    input  logic [4:0]    ps_dg_rd_add,
    input  logic [AW-1:0] bc_dt,
    output logic [AW-1:0] dg_dm_add,
    output logic [AW-1:0] dg_ps_add,
    output logic          dg_vld,
    output logic [AW-1:0] dg_bc_dt
);

    logic [AW-1:0] i_q [8];
    logic [AW-1:0] i_d [8];
    logic [AW-1:0] m_q [8];
    logic [AW-1:0] m_d [8];
`ifdef DAG_CIRC_BUF_EN
    logic [AW-1:0] l_q [8];
    logic [AW-1:0] l_d [8];
    logic [AW-1:0] b_q [8];
    logic [AW-1:0] b_d [8];
`endif
    logic [AW-1:0] addr_q, addr_d;
    logic          vld_q, vld_d;

    logic [AW-1:0] cur_i;
    logic [AW-1:0] mod_val;
    logic [AW-1:0] sum;
    logic [AW-1:0] wrapped;
    logic [2:0]    wr_idx;
    logic [2:0]    rd_idx;

    assign wr_idx = ps_dg_wrt_add[2:0];
    assign rd_idx = ps_dg_rd_add[2:0];

    always_comb begin
        cur_i   = i_q[ps_dg_iadd];
        mod_val = ps_dg_dgsclt ? ps_dg_immdt : m_q[ps_dg_madd];
        sum     = cur_i + mod_val;
        wrapped = sum;
`ifdef DAG_CIRC_BUF_EN
        // Direction of the wrap follows the sign of the modifier, not of the sum.
        if (l_q[ps_dg_iadd] != '0) begin
            if (!mod_val[AW-1] &&
                ({1'b0, sum} >= ({1'b0, b_q[ps_dg_iadd]} + {1'b0, l_q[ps_dg_iadd]})))
                wrapped = sum - l_q[ps_dg_iadd];
            else if (mod_val[AW-1] && (sum < b_q[ps_dg_iadd]))
                wrapped = sum + l_q[ps_dg_iadd];
        end
`endif
    end

    always_comb begin
        i_d    = i_q;
        m_d    = m_q;
`ifdef DAG_CIRC_BUF_EN
        l_d    = l_q;
        b_d    = b_q;
`endif
        addr_d = addr_q;
        vld_d  = ps_dg_en;
        if (ps_dg_en) begin
            if (ps_dg_mdfy) begin
                addr_d = wrapped;
            end else begin
                addr_d = cur_i;
                i_d[ps_dg_iadd] = wrapped;
            end
        end
        // Register-file writes come last so they override a post-modify update of the same I.
        if (ps_dg_wrt_en) begin
            case (ps_dg_wrt_add[4:3])
                2'b00: i_d[wr_idx] = bc_dt;
                2'b01: m_d[wr_idx] = bc_dt;
`ifdef DAG_CIRC_BUF_EN
                2'b10: l_d[wr_idx] = bc_dt;
                2'b11: begin
                    b_d[wr_idx] = bc_dt;
                    i_d[wr_idx] = bc_dt;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                i_q[k] <= '0;
                m_q[k] <= '0;
`ifdef DAG_CIRC_BUF_EN
                l_q[k] <= '0;
                b_q[k] <= '0;
`endif
            end
            addr_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            i_q    <= i_d;
            m_q    <= m_d;
`ifdef DAG_CIRC_BUF_EN
            l_q    <= l_d;
            b_q    <= b_d;
`endif
            addr_q <= addr_d;
            vld_q  <= vld_d;
        end
    end

    always_comb begin
        dg_bc_dt = '0;
        case (ps_dg_rd_add[4:3])
            2'b00: dg_bc_dt = i_q[rd_idx];
            2'b01: dg_bc_dt = m_q[rd_idx];
`ifdef DAG_CIRC_BUF_EN
            2'b10: dg_bc_dt = l_q[rd_idx];
            2'b11: dg_bc_dt = b_q[rd_idx];
`endif
            default: dg_bc_dt = '0;
        endcase
`ifdef DAG_CIRC_BUF_EN
        if (ps_dg_wrt_en && (ps_dg_wrt_add == ps_dg_rd_add))
            dg_bc_dt = bc_dt;
        if (ps_dg_wrt_en && (ps_dg_wrt_add[4:3] == 2'b11) &&
            (ps_dg_rd_add[4:3] == 2'b00) && (wr_idx == rd_idx))
            dg_bc_dt = bc_dt;
`else
        if (ps_dg_wrt_en && !ps_dg_wrt_add[4] && (ps_dg_wrt_add == ps_dg_rd_add))
            dg_bc_dt = bc_dt;
`endif
    end

    assign dg_dm_add = addr_q;
    assign dg_ps_add = addr_q;
    assign dg_vld    = vld_q;

endmodule

// File: tb/tb_dag_addr_gen.sv
// Bench for dag_addr_gen: vector table of register writes, reads and address requests,
// hand-written reset/collision/bypass sequences, and a small random post-modify loop.
module tb_dag_addr_gen;

`ifdef DAG_CIRC_BUF_EN
    localparam bit CIRC = 1'b1;
`else
    localparam bit CIRC = 1'b0;
`endif

    localparam int K_WR = 0;
    localparam int K_RD = 1;
    localparam int K_RQ = 2;

    typedef struct {
        int          kind;
        logic [4:0]  add;
        logic [15:0] data;
        logic [2:0]  iadd;
        logic [2:0]  madd;
        logic        dgsclt;
        logic        mdfy;
        logic [15:0] immdt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps_dg_en, ps_dg_dgsclt, ps_dg_mdfy;
    logic [2:0]  ps_dg_iadd, ps_dg_madd;
    logic [15:0] ps_dg_immdt;
    logic        ps_dg_wrt_en;
    logic [4:0]  ps_dg_wrt_add, ps_dg_rd_add;
    logic [15:0] bc_dt;
    logic [15:0] dg_dm_add, dg_ps_add, dg_bc_dt;
    logic        dg_vld;

    logic [15:0] exp_q[$];
    logic [15:0] last_addr;
    vec_t        tbl[$];
    int          n_cmp = 0;
    int          n_err = 0;

    dag_addr_gen #(.AW(16)) dut (
        .clk(clk), .rst(rst),
        .ps_dg_en(ps_dg_en), .ps_dg_dgsclt(ps_dg_dgsclt), .ps_dg_mdfy(ps_dg_mdfy),
        .ps_dg_iadd(ps_dg_iadd), .ps_dg_madd(ps_dg_madd), .ps_dg_immdt(ps_dg_immdt),
        .ps_dg_wrt_en(ps_dg_wrt_en), .ps_dg_wrt_add(ps_dg_wrt_add),
        .ps_dg_rd_add(ps_dg_rd_add), .bc_dt(bc_dt),
        .dg_dm_add(dg_dm_add), .dg_ps_add(dg_ps_add), .dg_vld(dg_vld), .dg_bc_dt(dg_bc_dt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // One clock of stimulus; read port checked before the edge, address port after it.
    task automatic step(input logic en, input logic dgsclt, input logic mdfy,
                        input logic [2:0] iadd, input logic [2:0] madd, input logic [15:0] immdt,
                        input logic wen, input logic [4:0] wadd, input logic [15:0] wdata,
                        input logic [4:0] radd, input logic chk_rd, input logic [15:0] exp_rd,
                        input logic [15:0] exp_addr);
        logic [15:0] e;
        @(negedge clk);
        ps_dg_en = en; ps_dg_dgsclt = dgsclt; ps_dg_mdfy = mdfy;
        ps_dg_iadd = iadd; ps_dg_madd = madd; ps_dg_immdt = immdt;
        ps_dg_wrt_en = wen; ps_dg_wrt_add = wadd; bc_dt = wdata; ps_dg_rd_add = radd;
        #1;
        if (chk_rd) check("rd_data", dg_bc_dt, exp_rd);
        if (en) exp_q.push_back(exp_addr);
        @(posedge clk);
        #1;
        check("vld", {15'd0, dg_vld}, {15'd0, en});
        if (dg_vld) begin
            if (exp_q.size() == 0) begin
                check("unexpected_addr", dg_dm_add, 16'hxxxx);
            end else begin
                e = exp_q.pop_front();
                check("dm_add", dg_dm_add, e);
                check("ps_add", dg_ps_add, e);
                last_addr = e;
            end
        end else begin
            check("hold_dm_add", dg_dm_add, last_addr);
            check("hold_ps_add", dg_ps_add, last_addr);
        end
    endtask

    task automatic s_wr(input logic [4:0] a, input logic [15:0] d);
        step(0, 0, 0, 0, 0, 0, 1, a, d, 0, 0, 0, 0);
    endtask
    task automatic s_rd(input logic [4:0] a, input logic [15:0] exp);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, a, 1, exp, 0);
    endtask
    task automatic s_rq(input logic [2:0] iadd, input logic [2:0] madd, input logic dgsclt,
                        input logic mdfy, input logic [15:0] immdt, input logic [15:0] exp);
        step(1, dgsclt, mdfy, iadd, madd, immdt, 0, 0, 0, 0, 0, 0, exp);
    endtask

    task automatic v_wr(input logic [4:0] a, input logic [15:0] d);
        tbl.push_back('{K_WR, a, d, 3'd0, 3'd0, 1'b0, 1'b0, 16'd0});
    endtask
    task automatic v_rd(input logic [4:0] a, input logic [15:0] exp);
        tbl.push_back('{K_RD, a, exp, 3'd0, 3'd0, 1'b0, 1'b0, 16'd0});
    endtask
    task automatic v_rq(input logic [2:0] iadd, input logic [2:0] madd, input logic dgsclt,
                        input logic mdfy, input logic [15:0] immdt, input logic [15:0] exp);
        tbl.push_back('{K_RQ, 5'd0, exp, iadd, madd, dgsclt, mdfy, immdt});
    endtask

    initial begin
        logic [15:0] ri, rm;
        rst = 1'b1;
        ps_dg_en = 0; ps_dg_dgsclt = 0; ps_dg_mdfy = 0; ps_dg_iadd = 0; ps_dg_madd = 0;
        ps_dg_immdt = 0; ps_dg_wrt_en = 0; ps_dg_wrt_add = 0; ps_dg_rd_add = 0; bc_dt = 0;
        last_addr = 16'h0000;

        // Table: post-modify, pre-modify with immediate, circular buffer forward/backward.
        v_wr(5'b00001, 16'h0100);
        v_wr(5'b01010, 16'h0004);
        v_rq(3'd1, 3'd2, 0, 0, 16'h0000, 16'h0100);
        v_rd(5'b00001, 16'h0104);
        v_rq(3'd1, 3'd2, 0, 0, 16'h0000, 16'h0104);
        v_rq(3'd1, 3'd2, 0, 0, 16'h0000, 16'h0108);
        v_rd(5'b00001, 16'h010C);
        v_wr(5'b00011, 16'h2000);
        v_rq(3'd3, 3'd0, 1, 1, 16'hFFFE, 16'h1FFE);
        v_rd(5'b00011, 16'h2000);
        v_wr(5'b11100, 16'h0040);
        v_rd(5'b00100, CIRC ? 16'h0040 : 16'h0000);
        v_wr(5'b00100, 16'h0040);
        v_wr(5'b10100, 16'h0003);
        v_wr(5'b01000, 16'h0001);
        v_rq(3'd4, 3'd0, 0, 0, 16'h0000, 16'h0040);
        v_rq(3'd4, 3'd0, 0, 0, 16'h0000, 16'h0041);
        v_rq(3'd4, 3'd0, 0, 0, 16'h0000, 16'h0042);
        v_rq(3'd4, 3'd0, 0, 0, 16'h0000, CIRC ? 16'h0040 : 16'h0043);
        v_rd(5'b00100, CIRC ? 16'h0041 : 16'h0044);
        v_rd(5'b10100, CIRC ? 16'h0003 : 16'h0000);
        v_rd(5'b11100, CIRC ? 16'h0040 : 16'h0000);
        v_wr(5'b00100, 16'h0040);
        v_wr(5'b01000, 16'hFFFF);
        v_rq(3'd4, 3'd0, 0, 0, 16'h0000, 16'h0040);
        v_rd(5'b00100, CIRC ? 16'h0042 : 16'h003F);

        // Reset: clears registers and address, and drops a request issued in the reset cycle.
        repeat (2) @(posedge clk);
        #1;
        check("reset_dm_add", dg_dm_add, 16'h0000);
        check("reset_vld", {15'd0, dg_vld}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        s_wr(5'b00000, 16'h1234);
        s_rd(5'b00000, 16'h1234);
        s_rq(3'd0, 3'd0, 1, 0, 16'h0000, 16'h1234);
        @(negedge clk);
        rst = 1'b1;
        ps_dg_en = 1; ps_dg_iadd = 0; ps_dg_dgsclt = 1; ps_dg_immdt = 16'h0001; ps_dg_mdfy = 0;
        @(posedge clk);
        #1;
        check("rst_mid_dm_add", dg_dm_add, 16'h0000);
        check("rst_mid_ps_add", dg_ps_add, 16'h0000);
        check("rst_mid_vld", {15'd0, dg_vld}, 16'h0000);
        last_addr = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        ps_dg_en = 0;
        s_rd(5'b00000, 16'h0000);

        for (int v = 0; v < tbl.size(); v++) begin
            case (tbl[v].kind)
                K_WR: s_wr(tbl[v].add, tbl[v].data);
                K_RD: s_rd(tbl[v].add, tbl[v].data);
                default: s_rq(tbl[v].iadd, tbl[v].madd, tbl[v].dgsclt, tbl[v].mdfy,
                              tbl[v].immdt, tbl[v].data);
            endcase
        end

        // Collision: ureg write to I5 beats the post-modify update in the same cycle.
        s_wr(5'b00101, 16'h0010);
        s_wr(5'b01101, 16'h0001);
        step(1, 0, 0, 3'd5, 3'd5, 0, 1, 5'b00101, 16'h0077, 0, 0, 0, 16'h0010);
        s_rd(5'b00101, 16'h0077);
        // Same-cycle M write does not reach address generation.
        step(1, 0, 0, 3'd5, 3'd5, 0, 1, 5'b01101, 16'h0005, 0, 0, 0, 16'h0077);
        s_rd(5'b00101, 16'h0078);

        // Read bypass: direct, B-into-I, and B-to-B.
        step(0, 0, 0, 0, 0, 0, 1, 5'b01110, 16'hABCD, 5'b01110, 1, 16'hABCD, 0);
        s_rd(5'b01110, 16'hABCD);
        step(0, 0, 0, 0, 0, 0, 1, 5'b11111, 16'h5555, 5'b00111, 1, CIRC ? 16'h5555 : 16'h0000, 0);
        step(0, 0, 0, 0, 0, 0, 1, 5'b11111, 16'h6666, 5'b11111, 1, CIRC ? 16'h6666 : 16'h0000, 0);
        s_rd(5'b00111, CIRC ? 16'h6666 : 16'h0000);

        // Random post-modify on I6 (L6 is zero, so no wrap in either build).
        for (int r = 0; r < 4; r++) begin
            ri = 16'($urandom_range(0, 16'hFFFF));
            rm = 16'($urandom_range(0, 16'hFFFF));
            s_wr(5'b00110, ri);
            s_wr(5'b01001, rm);
            s_rq(3'd6, 3'd1, 0, 0, 16'h0000, ri);
            s_rd(5'b00110, ri + rm);
            s_rq(3'd6, 3'd0, 1, 1, rm, ri + rm + rm);
        end

        if (exp_q.size() != 0) check("exp_q_drained", 16'(exp_q.size()), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
